// File: rtl/unconfig_int_pkg.sv
// Shared definitions for the nibble-serial subtractor.
// Holds the default operand width, the slice width processed per cycle,
// the resulting slice count and the controller state type.
package unconfig_int_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_NIB   = 4;
  localparam int unsigned NUM_NIB       = DEFAULT_WIDTH / DEFAULT_NIB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ripple_adder_4bit.sv
// 4-bit adder with carry-in and carry-out.
// Ports:
//   A, B  - 4-bit addends
//   Cin   - carry in
//   Sum   - 4-bit sum
//   Cout  - carry out
module ripple_adder_4bit (
  output logic [3:0] Sum,
  output logic       Cout,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin
);

  assign {Cout, Sum} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

endmodule

// File: rtl/unconfig_int_sub_seq.sv
// Sequential subtractor: computes c = a - b one NIB-bit slice per cycle,
// LSB first, as a + ~b + 1 through a single 4-bit adder.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid / in_ready  - operand handshake (a = minuend, b = subtrahend)
//   out_valid / out_ready- result handshake
//   c                    - difference modulo 2^WIDTH
//   borrow               - unsigned a < b
//   overflow             - signed a - b out of range
// NIB must match the adder slice width (4).
module unconfig_int_sub_seq
  import unconfig_int_pkg::*;
#(
  parameter int unsigned WIDTH = unconfig_int_pkg::DEFAULT_WIDTH,
  parameter int unsigned NIB   = unconfig_int_pkg::DEFAULT_NIB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             borrow,
  output logic             overflow
);

  localparam int unsigned NumNib = WIDTH / NIB;
  localparam int unsigned CntW   = (NumNib > 1) ? $clog2(NumNib) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumNib - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  c_q, c_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              borrow_q, borrow_d;
  logic              overflow_q, overflow_d;

  logic [NIB-1:0]    a_slice;
  logic [NIB-1:0]    b_slice;
  logic [NIB-1:0]    sum_slice;
  logic              slice_cout;

  assign a_slice = a_q[cnt_q*NIB +: NIB];
  assign b_slice = b_q[cnt_q*NIB +: NIB];

  // Subtraction as a + ~b with the carry register seeded to 1 on acceptance.
  ripple_adder_4bit u_adder (
    .Sum  (sum_slice),
    .Cout (slice_cout),
    .A    (a_slice),
    .B    (~b_slice),
    .Cin  (carry_q)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE) && !rst;
  assign c         = c_q;
  assign borrow    = borrow_q;
  assign overflow  = overflow_q;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    borrow_d   = borrow_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d        = a;
          b_d        = b;
          c_d        = '0;
          cnt_d      = '0;
          carry_d    = 1'b1;
          borrow_d   = 1'b0;
          overflow_d = 1'b0;
          state_d    = RUN;
        end
      end

      RUN: begin
        c_d[cnt_q*NIB +: NIB] = sum_slice;
        carry_d               = slice_cout;
        if (cnt_q == LastCnt) begin
          cnt_d      = '0;
          state_d    = DONE;
          // Final slice carries the result MSB, so flags use it directly.
          borrow_d   = ~slice_cout;
          overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                       (sum_slice[NIB-1] != a_q[WIDTH-1]);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      borrow_q   <= borrow_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_unconfig_int_sub_seq.sv
// Self-checking bench for unconfig_int_sub_seq: directed corner cases,
// held-off result, mid-run reset, then back-to-back random operands
// compared against an arithmetic reference model.
module tb_unconfig_int_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] c;
  logic        borrow;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  unconfig_int_sub_seq #(
    .WIDTH (32),
    .NIB   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .borrow    (borrow),
    .overflow  (overflow)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {c, borrow, overflow} from plain integer arithmetic.
  function automatic logic [33:0] ref_sub(input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      sd;
    logic [31:0] d;
    logic        bw;
    logic        ov;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sd = sx - sy;
    ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    bw = (x < y);
    d  = x - y;
    return {d, bw, ov};
  endfunction

  // Called just after a falling edge with the DUT idle.
  task automatic do_op(input logic [31:0] xa, input logic [31:0] xb, input int hold,
                       input bit noise, output int acc_cyc);
    logic [33:0] exp;
    int          lat;
    exp       = ref_sub(xa, xb);
    in_valid  = 1'b1;
    a         = xa;
    b         = xb;
    out_ready = (hold == 0);
    #1;
    check_eq("in_ready_idle", in_ready, 1);
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    lat      = 0;
    while (!out_valid && lat < 40) begin
      check_eq("in_ready_run", in_ready, 0);
      if (noise) in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("latency", lat, 8);
    check_eq("c", c, exp[33:2]);
    check_eq("borrow", borrow, exp[1]);
    check_eq("overflow", overflow, exp[0]);
    for (int i = 0; i < hold; i++) begin
      check_eq("hold_out_valid", out_valid, 1);
      check_eq("hold_in_ready", in_ready, 0);
      in_valid = 1'b1;
      a        = $urandom;
      b        = $urandom;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check_eq("hold_c", c, exp[33:2]);
      check_eq("hold_borrow", borrow, exp[1]);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check_eq("post_hs_out_valid", out_valid, 0);
    check_eq("post_hs_in_ready", in_ready, 1);
  endtask

  initial begin
    int acc;
    int prev;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_c", c, 0);
    check_eq("rst_borrow", borrow, 0);
    check_eq("rst_overflow", overflow, 0);
    rst = 1'b0;
    #1;
    check_eq("rst_release_in_ready", in_ready, 1);

    do_op(32'h0000_0005, 32'h0000_0003, 0, 1'b0, acc);
    do_op(32'h0000_0000, 32'h0000_0001, 0, 1'b0, acc);
    do_op(32'h8000_0000, 32'h0000_0001, 0, 1'b0, acc);
    do_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 5, 1'b1, acc);

    // Reset during the 4th RUN cycle aborts the operation.
    in_valid = 1'b1;
    a        = 32'h1234_5678;
    b        = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrun_rst_in_ready", in_ready, 0);
    check_eq("midrun_rst_out_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("after_rst_out_valid", out_valid, 0);
    check_eq("after_rst_in_ready", in_ready, 1);
    check_eq("after_rst_c", c, 0);
    check_eq("after_rst_borrow", borrow, 0);
    check_eq("after_rst_overflow", overflow, 0);
    do_op(32'h0000_0010, 32'h0000_0020, 0, 1'b0, acc);

    // Back-to-back random operands, result accepted immediately.
    prev = -1;
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 6 == 1) ra = 32'h7FFF_FFFF;
      if (i % 6 == 2) rb = 32'h8000_0000;
      if (i % 6 == 3) rb = ra;
      do_op(ra, rb, 0, 1'b1, acc);
      if (prev >= 0) check_eq("interval", acc - prev, 10);
      prev = acc;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/unconfig_int_sub_seq.md
UNCONFIG_INT_SUB_SEQ -- requirements
Module: unconfig_int_sub_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter NIB, default 4, bits processed per cycle; WIDTH SHALL be a multiple of NIB.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operands a/b valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  WIDTH  minuend.
REQ-008 b  input  WIDTH  subtrahend.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 c  output  WIDTH  difference a - b, modulo 2^WIDTH.
REQ-012 borrow  output  1  1 when unsigned a < unsigned b.
REQ-013 overflow  output  1  1 when signed two's-complement a - b is out of range.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE and rst low; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE: on in_valid && in_ready, the block SHALL latch a and b, clear the nibble counter, set carry register to 1, and go to RUN.
REQ-017 RUN: each cycle, the block SHALL compute one NIB-bit slice (LSB first) as a_slice + ~b_slice + carry, store the sum slice into c, and update carry with the slice carry-out.
REQ-018 RUN SHALL last exactly WIDTH/NIB cycles (8 at defaults); the counter SHALL wrap from WIDTH/NIB-1 to DONE, never beyond.
REQ-019 Latency: out_valid SHALL rise exactly WIDTH/NIB clock edges after the accepting edge (8 at defaults).
REQ-020 On entry to DONE: borrow = ~final carry; overflow = (a[MSB] != b[MSB]) && (c[MSB] != a[MSB]).
REQ-021 DONE: c, borrow, overflow SHALL stay stable until out_valid && out_ready, then the FSM SHALL return to IDLE.
REQ-022 in_valid in RUN or DONE SHALL be ignored; operand changes after acceptance SHALL NOT affect the result.
REQ-023 The output handshake and a new input acceptance SHALL NOT occur in the same cycle; minimum initiation interval is WIDTH/NIB + 2 cycles.
REQ-024 Inputs a and b SHALL be treated as raw bit vectors; the result is identical for signed and unsigned interpretation, only borrow/overflow differ.

Reset
REQ-025 rst high at a clock edge SHALL force IDLE, c=0, borrow=0, overflow=0, carry=0, counter=0, regardless of current state.
REQ-026 in_ready and out_valid SHALL be 0 while rst is high; in_ready SHALL be 1 in the first cycle after rst falls.
REQ-027 Reset asserted mid-RUN or in DONE SHALL discard the in-flight operation with no output handshake.

Structure
REQ-028 Package unconfig_int_pkg SHALL hold WIDTH and NIB defaults, NUM_NIB = WIDTH/NIB, and the state enum typedef (IDLE, RUN, DONE).
REQ-029 The slice arithmetic SHALL be one instance of the existing ripple_adder_4bit (ports Sum, Cout, A, B, Cin), with B driven by the inverted b slice and Cin by the carry register.
REQ-030 No other sub-module SHALL be instantiated; the FSM, counter, and operand/result registers are local.

Verification
REQ-031 a=0x00000005, b=0x00000003 -> c=0x00000002, borrow=0, overflow=0, out_valid exactly 8 edges after acceptance.
REQ-032 a=0x00000000, b=0x00000001 -> c=0xFFFFFFFF, borrow=1, overflow=0.
REQ-033 a=0x80000000, b=0x00000001 -> c=0x7FFFFFFF, borrow=0, overflow=1.
REQ-034 a=b=0xDEADBEEF with out_ready held low 5 cycles in DONE -> c=0x00000000 stable, in_ready=0, in_valid pulses ignored, then one handshake.
REQ-035 rst pulsed in the 4th RUN cycle -> next cycle IDLE, c=0, out_valid=0, in_ready=1; a following a=0x10, b=0x20 yields c=0xFFFFFFF0, borrow=1.
REQ-036 Back-to-back random operands with out_ready=1 -> each result matches a reference model, and the interval between acceptances is 10 cycles.
